// File: rtl/pcie_gear_pkg.sv
// Shared gearbox definitions: FSM state encodings, COM/IDLE symbols and symbol bit positions.
// Used by the Rx alignment bridge and the Tx-side gearing logic.
package pcie_gear_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_HUNT     = 2'd2,
    ST_LOCKED   = 2'd3
  } gear_state_e;

  localparam int         K_BIT       = 8;
  localparam int         STAT_BIT    = 9;
  localparam logic [7:0] COM_SYM_DEF = 8'hBC;
  // Electrical-idle marker: status bit set, everything else clear.
  localparam logic [9:0] IDLE_SYM    = 10'(1 << STAT_BIT);

endpackage

// File: rtl/rx_gear_align.sv
// Rx symbol gearbox: packs one 10-bit symbol per clk_250 into COM-aligned 20-bit pairs.
// Optional saturating realign counter when RX_GEAR_ALIGN_STATS_EN is defined.
module rx_gear_align
  import pcie_gear_pkg::*;
#(
  parameter int         GWIDTH     = 20,
  parameter logic [7:0] COM_SYM    = COM_SYM_DEF,
  parameter int         SETTLE_CYC = 8
) (
  input  logic                clk_250,
  input  logic                rst,
  input  logic                drate_enable,
  input  logic [GWIDTH/2-1:0] data_in,
  output logic [GWIDTH-1:0]   data_out,
  output logic                data_valid,
  output logic                locked,
  output logic                realign
`ifdef RX_GEAR_ALIGN_STATS_EN
  ,output logic [7:0]         realign_cnt
`endif
);

  localparam int              SW          = GWIDTH / 2;
  localparam logic [SW-1:0]   IDLE        = SW'(IDLE_SYM);
  localparam logic [4:0]      SETTLE_LAST = 5'(SETTLE_CYC - 1);

  gear_state_e       state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [SW-1:0]     lower_q, lower_d;
  logic [GWIDTH-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              realign_q, realign_d;
  logic              is_com;

  assign is_com = data_in[K_BIT] & (data_in[7:0] == COM_SYM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    lower_d    = lower_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    realign_d  = 1'b0;
    if (!drate_enable) begin
      // Dropping enable abandons any half-built pair and parks the outputs at idle.
      state_d    = ST_DISABLED;
      cnt_d      = '0;
      phase_d    = 1'b0;
      lower_d    = IDLE;
      data_out_d = {IDLE, IDLE};
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_d == SETTLE_LAST) state_d = ST_HUNT;
        end
        ST_HUNT: begin
          if (is_com) begin
            lower_d  = data_in;
            phase_d  = 1'b1;
            locked_d = 1'b1;
            state_d  = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (!phase_q) begin
            lower_d = data_in;
            phase_d = 1'b1;
          end else if (is_com) begin
            // COM on the upper slot: slip one symbol so it becomes the new lower half.
            lower_d   = data_in;
            realign_d = 1'b1;
          end else begin
            data_out_d = {data_in, lower_q};
            valid_d    = 1'b1;
            phase_d    = 1'b0;
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk_250 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DISABLED;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      lower_q    <= IDLE;
      data_out_q <= {IDLE, IDLE};
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      realign_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      lower_q    <= lower_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      realign_q  <= realign_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign locked     = locked_q;
  assign realign    = realign_q;

`ifdef RX_GEAR_ALIGN_STATS_EN
  logic [7:0] realign_cnt_q, realign_cnt_d;

  always_comb begin
    realign_cnt_d = realign_cnt_q;
    if (state_d == ST_DISABLED) realign_cnt_d = '0;
    else if (realign_d && (realign_cnt_q != 8'hFF)) realign_cnt_d = realign_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_250 or posedge rst) begin
    if (rst) realign_cnt_q <= '0;
    else     realign_cnt_q <= realign_cnt_d;
  end

  assign realign_cnt = realign_cnt_q;
`endif

endmodule

// File: tb/tb_rx_gear_align.sv
// Self-checking bench for rx_gear_align: scoreboard of expected pairs plus per-cycle strobe checks.
// Exercises the realign counter when RX_GEAR_ALIGN_STATS_EN is defined.
module tb_rx_gear_align;

  localparam int GW = 20;
  localparam int SW = 10;
  localparam logic [GW-1:0] IDLE_PAIR = {10'h200, 10'h200};
  localparam logic [SW-1:0] COM       = 10'h1BC;

  logic          clk_250      = 1'b0;
  logic          rst          = 1'b1;
  logic          drate_enable = 1'b0;
  logic [SW-1:0] data_in      = '0;
  logic [GW-1:0] data_out;
  logic          data_valid;
  logic          locked;
  logic          realign;
`ifdef RX_GEAR_ALIGN_STATS_EN
  logic [7:0]    realign_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] exp_pair;

  rx_gear_align dut (
    .clk_250      (clk_250),
    .rst          (rst),
    .drate_enable (drate_enable),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .locked       (locked),
    .realign      (realign)
`ifdef RX_GEAR_ALIGN_STATS_EN
    ,.realign_cnt (realign_cnt)
`endif
  );

  always #2 clk_250 = ~clk_250;

  // One symbol cycle; on return the outputs show the registered result of that cycle.
  task automatic cyc(input logic en, input logic [SW-1:0] sym);
    drate_enable = en;
    data_in      = sym;
    @(posedge clk_250);
    #1;
  endtask

  function automatic logic [SW-1:0] rand_sym();
    logic [SW-1:0] s;
    s = SW'($urandom);
    if (s[8] && (s[7:0] == 8'hBC)) s[0] = ~s[0];
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    drate_enable = 1'b0;
    repeat (2) @(posedge clk_250);
    #1;
    checks++;
    if ({data_out, data_valid, locked, realign} !== {IDLE_PAIR, 3'b000}) begin
      failures++;
      $display("FAIL reset_vals: data_out=%h valid=%b locked=%b realign=%b, required %h 0 0 0",
               data_out, data_valid, locked, realign, IDLE_PAIR);
    end
    rst = 1'b0;
    repeat (2) cyc(1'b0, 10'h3FF);
    checks++;
    if ({data_out, data_valid, locked} !== {IDLE_PAIR, 2'b00}) begin
      failures++;
      $display("FAIL disabled_idle: data_out=%h valid=%b locked=%b, required %h 0 0",
               data_out, data_valid, locked, IDLE_PAIR);
    end
  endtask

  task automatic test_settle_lock();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 10'h000);
      checks++;
      if ({locked, data_valid} !== 2'b00) begin
        failures++;
        $display("FAIL settle_cyc%0d: locked=%b valid=%b, required 0 0", i + 1, locked, data_valid);
      end
    end
    cyc(1'b1, COM);
    checks++;
    if ({locked, data_valid} !== 2'b10) begin
      failures++;
      $display("FAIL lock_cyc9: locked=%b valid=%b, required 1 0", locked, data_valid);
    end
    exp_q.push_back({10'h055, COM});
    cyc(1'b1, 10'h055);
    checks++;
    if (data_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL lock_pair_valid: valid=%b queued=%0d, required 1 with a queued pair",
               data_valid, exp_q.size());
    end else begin
      exp_pair = exp_q.pop_front();
      if (data_out !== exp_pair) begin
        failures++;
        $display("FAIL lock_pair_data: data_out=%h, required %h", data_out, exp_pair);
      end
    end
  endtask

  task automatic test_stream(input int npairs);
    logic [SW-1:0] a, b;
    for (int p = 0; p < npairs; p++) begin
      a = (p % 97 == 5) ? COM : rand_sym();
      b = rand_sym();
      cyc(1'b1, a);
      checks++;
      if ({data_valid, realign, locked} !== 3'b001) begin
        failures++;
        $display("FAIL stream_gap p%0d: valid=%b realign=%b locked=%b, required 0 0 1",
                 p, data_valid, realign, locked);
      end
      exp_q.push_back({b, a});
      cyc(1'b1, b);
      checks++;
      if (data_valid !== 1'b1 || realign !== 1'b0 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL stream_strobe p%0d: valid=%b realign=%b queued=%0d, required 1 0 with a queued pair",
                 p, data_valid, realign, exp_q.size());
      end else begin
        exp_pair = exp_q.pop_front();
        if (data_out !== exp_pair) begin
          failures++;
          $display("FAIL stream_data p%0d: data_out=%h, required %h", p, data_out, exp_pair);
        end
      end
    end
  endtask

  task automatic test_realign();
    logic [SW-1:0] a, b;
    for (int r = 0; r < 6; r++) begin
      a = rand_sym();
      b = rand_sym();
      cyc(1'b1, a);
      checks++;
      if ({data_valid, realign} !== 2'b00) begin
        failures++;
        $display("FAIL realign_pre r%0d: valid=%b realign=%b, required 0 0", r, data_valid, realign);
      end
      cyc(1'b1, COM);
      checks++;
      if ({data_valid, realign, locked} !== 3'b011) begin
        failures++;
        $display("FAIL realign_pulse r%0d: valid=%b realign=%b locked=%b, required 0 1 1",
                 r, data_valid, realign, locked);
      end
      exp_q.push_back({b, COM});
      cyc(1'b1, b);
      checks++;
      if (data_valid !== 1'b1 || realign !== 1'b0 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL realign_strobe r%0d: valid=%b realign=%b queued=%0d, required 1 0 with a queued pair",
                 r, data_valid, realign, exp_q.size());
      end else begin
        exp_pair = exp_q.pop_front();
        if (data_out !== exp_pair) begin
          failures++;
          $display("FAIL realign_data r%0d: data_out=%h, required %h", r, data_out, exp_pair);
        end
      end
    end
  endtask

  task automatic test_disable();
    logic [SW-1:0] b;
    cyc(1'b1, rand_sym());
    cyc(1'b0, rand_sym());
    checks++;
    if ({data_out, data_valid, locked, realign} !== {IDLE_PAIR, 3'b000}) begin
      failures++;
      $display("FAIL disable_drop: data_out=%h valid=%b locked=%b realign=%b, required %h 0 0 0",
               data_out, data_valid, locked, realign, IDLE_PAIR);
    end
    // COMs during the settle window must be ignored.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, COM);
      checks++;
      if ({data_valid, locked} !== 2'b00) begin
        failures++;
        $display("FAIL resettle_cyc%0d: valid=%b locked=%b, required 0 0", i + 1, data_valid, locked);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, rand_sym());
      checks++;
      if ({data_valid, locked} !== 2'b00) begin
        failures++;
        $display("FAIL rehunt_cyc%0d: valid=%b locked=%b, required 0 0", i, data_valid, locked);
      end
    end
    cyc(1'b1, COM);
    checks++;
    if ({data_valid, locked} !== 2'b01) begin
      failures++;
      $display("FAIL relock: valid=%b locked=%b, required 0 1", data_valid, locked);
    end
    b = rand_sym();
    exp_q.push_back({b, COM});
    cyc(1'b1, b);
    checks++;
    if (data_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL relock_strobe: valid=%b queued=%0d, required 1 with a queued pair",
               data_valid, exp_q.size());
    end else begin
      exp_pair = exp_q.pop_front();
      if (data_out !== exp_pair) begin
        failures++;
        $display("FAIL relock_data: data_out=%h, required %h", data_out, exp_pair);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [SW-1:0] a, b;
    a = rand_sym();
    b = rand_sym();
    cyc(1'b1, a);
    exp_q.push_back({b, a});
    cyc(1'b1, b);
    checks++;
    if (data_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL prereset_strobe: valid=%b queued=%0d, required 1 with a queued pair",
               data_valid, exp_q.size());
    end else begin
      exp_pair = exp_q.pop_front();
      if (data_out !== exp_pair) begin
        failures++;
        $display("FAIL prereset_data: data_out=%h, required %h", data_out, exp_pair);
      end
    end
    // Reset raised between clock edges must take effect without waiting for one.
    rst = 1'b1;
    #1;
    checks++;
    if ({data_out, data_valid, locked, realign} !== {IDLE_PAIR, 3'b000}) begin
      failures++;
      $display("FAIL async_reset: data_out=%h valid=%b locked=%b realign=%b, required %h 0 0 0",
               data_out, data_valid, locked, realign, IDLE_PAIR);
    end
    drate_enable = 1'b0;
    @(posedge clk_250);
    #1;
    rst = 1'b0;
    cyc(1'b0, 10'h000);
  endtask

`ifdef RX_GEAR_ALIGN_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < 8; i++) cyc(1'b1, 10'h000);
    cyc(1'b1, COM);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL stats_lock: locked=%b, required 1", locked);
    end
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, COM);
      checks++;
      if (realign !== 1'b1) begin
        failures++;
        $display("FAIL stats_pulse i%0d: realign=%b, required 1", i, realign);
      end
      if (i == 9) begin
        checks++;
        if (realign_cnt !== 8'd10) begin
          failures++;
          $display("FAIL stats_cnt10: realign_cnt=%0d, required 10", realign_cnt);
        end
      end
    end
    checks++;
    if (realign_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL stats_sat: realign_cnt=%h, required ff", realign_cnt);
    end
    cyc(1'b0, 10'h000);
    checks++;
    if (realign_cnt !== 8'h00) begin
      failures++;
      $display("FAIL stats_clear: realign_cnt=%h, required 00", realign_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_settle_lock();
    test_stream(1000);
    test_realign();
    test_disable();
    test_async_reset();
`ifdef RX_GEAR_ALIGN_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: queued=%0d, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
